// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - tx_state_t      : transmitter FSM states (IDLE, START, DATA, STOP)
//   - DATA_OFS        : byte offset of the DATA register from BASE_ADDR
//   - STATUS_OFS      : byte offset of the STATUS register from BASE_ADDR
//   - STAT_* indices  : bit positions inside the STATUS word
//   - pack_status()   : assembles the 32-bit STATUS read value
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [31:0] DATA_OFS   = 32'd0;
    localparam logic [31:0] STATUS_OFS = 32'd4;

    // STATUS layout: {25'b0, count[3:0], ovf, full, busy}
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 4;

    function automatic logic [31:0] pack_status(
        input logic [STAT_CNT_W-1:0] cnt,
        input logic                  ovf,
        input logic                  full,
        input logic                  busy
    );
        logic [31:0] s;
        s                              = '0;
        s[STAT_BUSY]                   = busy;
        s[STAT_FULL]                   = full;
        s[STAT_OVF]                    = ovf;
        s[STAT_CNT_LSB +: STAT_CNT_W]  = cnt;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Byte queue between the CPU store port and the serialiser. The head entry is
// always visible on dout, so a pop and the use of the popped byte happen in
// the same cycle. A push while full is taken only when a pop frees the slot
// in the same cycle; pointers wrap modulo DEPTH.
//
// Parameters:
//   DEPTH  number of entries (1..15)
//   WIDTH  entry width in bits
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   push   write din at the tail (ignored when full and no pop)
//   pop    remove the head entry (ignored when empty)
//   din    data to push
//   dout   current head entry
//   count  number of valid entries
//   full   count == DEPTH
//   empty  count == 0
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [3:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [3:0]       r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty     = (r_count == 4'd0);
    assign full      = (r_count == 4'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 4'd0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
// Memory-mapped 8N1 UART transmitter for a small CPU data bus.
//   BASE_ADDR     DATA   (write: queue byte dmem_data_in[7:0]; read: 0)
//   BASE_ADDR+4   STATUS (read: {25'b0, count[3:0], ovf, full, busy};
//                         write: clear sticky ovf)
// Any other address reads 0 and writes are ignored.
//
// Build option: define UART_TX_FIFO_EN for a 4-entry queue; without it the
// queue is a single holding register. The register map is the same.
//
// Parameters:
//   CLK_HZ     system clock frequency in Hz
//   BAUD       serial bit rate; bit period is CLK_HZ/BAUD cycles (truncated)
//   BASE_ADDR  address of the DATA register
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   dmem_wren      store strobe, one cycle per store
//   dmem_address   CPU data address
//   dmem_data_in   store data, bits [7:0] used
//   funct3         access size, ignored
//   dmem_data_out  read data, registered (one-cycle latency)
//   tx             serial output, idle high, driven from a flop
// ---------------------------------------------------------------------------
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int          CLK_HZ    = 12000000,
    parameter int          BAUD      = 115200,
    parameter logic [31:0] BASE_ADDR = 32'hFFFFFFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        tx
);

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BAUD_W-1:0] DIV_M1 = BAUD_W'(DIV - 1);

    localparam logic [31:0] DATA_ADDR   = BASE_ADDR + DATA_OFS;
    localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    tx_state_t         r_state;
    logic              r_tx;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [7:0]        r_shift;
    logic [2:0]        r_bit_idx;
    logic              r_ovf;
    logic [31:0]       r_rdata;

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    logic       w_data_wr;
    logic       w_status_wr;
    logic       w_bit_end;
    logic       w_pop;
    logic       w_ovf_set;
    logic       w_busy;
    logic [7:0] w_fifo_dout;
    logic [3:0] w_fifo_count;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_unused;

    // Size field and upper store-data bits are part of the bus but unused.
    assign w_unused    = ^{funct3, dmem_data_in[31:8]};

    assign w_data_wr   = dmem_wren && (dmem_address == DATA_ADDR);
    assign w_status_wr = dmem_wren && (dmem_address == STATUS_ADDR);
    assign w_bit_end   = (r_baud_cnt == '0);
    assign w_busy      = (r_state != ST_IDLE);

    // The FSM takes a byte either when leaving IDLE or when a STOP bit ends
    // with more data queued (back-to-back frames without an idle bit).
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    // A DATA write is lost only if the queue is full and nothing leaves it
    // in the same cycle.
    assign w_ovf_set = w_data_wr && w_fifo_full && !w_pop;

    assign tx            = r_tx;
    assign dmem_data_out = r_rdata;

    // ---------------------------------------------------------------------
    // Transmit queue
    // ---------------------------------------------------------------------
    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_data_wr),
        .pop   (w_pop),
        .din   (dmem_data_in[7:0]),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // ---------------------------------------------------------------------
    // Serialiser FSM. The baud counter is reloaded on every state entry and
    // at every bit boundary, so each bit lasts exactly DIV cycles.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_state    <= ST_START;
                        r_shift    <= w_fifo_dout;
                        r_baud_cnt <= DIV_M1;
                        r_tx       <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_state    <= ST_DATA;
                        r_tx       <= r_shift[0];
                        r_shift    <= {1'b0, r_shift[7:1]};
                        r_bit_idx  <= 3'd0;
                        r_baud_cnt <= DIV_M1;
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= DIV_M1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= DIV_M1;
                        if (!w_fifo_empty) begin
                            r_state <= ST_START;
                            r_shift <= w_fifo_dout;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Sticky overflow flag: a new overflow wins over a clearing write.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_status_wr) begin
            r_ovf <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Registered read port: only STATUS returns data, everything else is 0.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (dmem_address == STATUS_ADDR) begin
            r_rdata <= pack_status(w_fifo_count, r_ovf, w_fifo_full, w_busy);
        end else begin
            r_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
// Scoreboard bench for uart_tx_periph with default parameters (bit period
// 104 cycles). Stimulus tasks drive the bus and push expected frames and
// expected read values into queues; two monitors pop and compare:
//   frame_mon : follows every frame on tx cycle by cycle
//   rd_mon    : compares dmem_data_out one cycle after each read
// The queue-depth scenario follows UART_TX_FIFO_EN.
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam int          BIT_CYC   = 104;          // 12e6 / 115200 truncated
    localparam int          FRAME_CYC = 10 * BIT_CYC;
    localparam logic [31:0] A_DATA    = 32'hFFFFFFE0;
    localparam logic [31:0] A_STAT    = 32'hFFFFFFE4;
    localparam logic [31:0] A_BAD     = 32'hFFFFFFE8;

    logic        clk = 1'b0;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;
    logic [31:0] dmem_data_out;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_periph dut (
        .clk           (clk),
        .reset         (reset),
        .dmem_wren     (dmem_wren),
        .dmem_address  (dmem_address),
        .dmem_data_in  (dmem_data_in),
        .funct3        (funct3),
        .dmem_data_out (dmem_data_out),
        .tx            (tx)
    );

    typedef struct {
        logic [7:0] data;
        bit         b2b;        // must start the cycle after the previous frame
        bit         will_abort; // a reset is planned during this frame
    } frame_exp_t;

    typedef struct {
        logic [31:0] value;
        string       name;
    } rd_exp_t;

    frame_exp_t frame_q[$];
    rd_exp_t    rd_q[$];

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    logic rst_seen;
    logic rd_req   = 1'b0;
    logic rd_req_d = 1'b0;
    bit   mon_en   = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
        rd_req_d <= rd_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic flag(input string name, input string msg);
        n_total++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // ------------------------------------------------------------------
    // Bus tasks: each owns exactly one cycle, driven at the falling edge.
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [31:0] addr, input logic [7:0] data);
        @(negedge clk);
        dmem_wren    = 1'b1;
        dmem_address = addr;
        dmem_data_in = {24'hABCDEF, data};   // upper bits must be ignored
        funct3       = 3'b010;
        rd_req       = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        rd_exp_t e;
        @(negedge clk);
        dmem_wren    = 1'b0;
        dmem_address = addr;
        rd_req       = 1'b1;
        e.value      = exp;
        e.name       = name;
        rd_q.push_back(e);
    endtask

    task automatic bus_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dmem_wren    = 1'b0;
            dmem_address = 32'h0;
            rd_req       = 1'b0;
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit b2b, input bit ab);
        frame_exp_t e;
        e.data       = d;
        e.b2b        = b2b;
        e.will_abort = ab;
        frame_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Read monitor
    // ------------------------------------------------------------------
    initial begin : rd_mon
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_req_d && rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check(e.name, dmem_data_out, e.value);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame monitor: compares tx against the ideal waveform every cycle.
    // ------------------------------------------------------------------
    initial begin : frame_mon
        frame_exp_t e;
        logic [9:0] bits;
        logic [7:0] got;
        int         errs;
        int         start_cyc;
        int         prev_end;
        int         last_end;
        bit         aborted;
        bit         have_e;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (!mon_en || rst_seen || tx !== 1'b0) continue;
            start_cyc = cyc;
            errs      = 0;
            got       = '0;
            aborted   = 1'b0;
            have_e    = (frame_q.size() > 0);
            if (have_e) begin
                e = frame_q.pop_front();
            end else begin
                e.data       = 8'h00;
                e.b2b        = 1'b0;
                e.will_abort = 1'b0;
                flag("unexpected_frame", $sformatf("start bit at cycle %0d, expected no frame", start_cyc));
            end
            bits = {1'b1, e.data, 1'b0};
            for (int i = 0; i < FRAME_CYC; i++) begin
                if (i > 0) @(negedge clk);
                if (rst_seen) begin
                    aborted = 1'b1;
                    break;
                end
                if (tx !== bits[i / BIT_CYC]) errs++;
                if ((i % BIT_CYC) == BIT_CYC / 2 && (i / BIT_CYC) >= 1 && (i / BIT_CYC) <= 8)
                    got[i / BIT_CYC - 1] = tx;
            end
            prev_end = last_end;
            if (!aborted) last_end = cyc;
            if (have_e) begin
                if (e.will_abort) begin
                    check("frame_cut_by_reset", 32'(aborted), 32'd1);
                end else if (aborted) begin
                    flag("frame_aborted", $sformatf("frame 0x%02h cut short", e.data));
                end else begin
                    check("frame_data", {24'h0, got}, {24'h0, e.data});
                    check("frame_shape_errs", errs, 0);
                    if (e.b2b) check("frame_gap", start_cyc, prev_end + 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin : watchdog
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        reset        = 1'b1;
        dmem_wren    = 1'b0;
        dmem_address = 32'h0;
        dmem_data_in = 32'h0;
        funct3       = 3'b000;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("tx_idle_after_reset", 32'(tx), 32'd1);
        mon_en = 1'b1;

        bus_read(A_STAT, 32'h0, "status_after_reset");
        bus_read(A_DATA, 32'h0, "data_reads_zero");

        // Single frame 0x55; STATUS read mid-frame: busy, count 0.
        bus_write(A_DATA, 8'h55);
        expect_frame(8'h55, 1'b0, 1'b0);
        bus_idle(200);
        bus_read(A_STAT, 32'h0000_0001, "status_busy_first_frame");
        bus_idle(900);
        bus_read(A_STAT, 32'h0, "status_idle_after_frame");

`ifdef UART_TX_FIFO_EN
        // A priming byte keeps the FSM in START so no pop overlaps the burst:
        // 0x41..0x44 fill the 4 entries, 0x45 finds the queue full.
        bus_write(A_DATA, 8'h00);
        expect_frame(8'h00, 1'b0, 1'b0);
        bus_idle(3);
        for (int k = 0; k < 5; k++) bus_write(A_DATA, 8'(8'h41 + k));
        for (int k = 0; k < 4; k++) expect_frame(8'(8'h41 + k), 1'b1, 1'b0);
        bus_read(A_STAT, 32'h0000_0027, "status_full_ovf");     // cnt4 ovf full busy
        bus_write(A_STAT, 8'h00);
        bus_read(A_STAT, 32'h0000_0023, "status_ovf_cleared");
        bus_idle(5 * FRAME_CYC + 100);
        bus_read(A_STAT, 32'h0, "status_drained");
`else
        // Second write lands on the IDLE->START pop: accepted, no overflow.
        bus_write(A_DATA, 8'hA3);
        bus_write(A_DATA, 8'h3C);
        expect_frame(8'hA3, 1'b0, 1'b0);
        expect_frame(8'h3C, 1'b1, 1'b0);
        bus_read(A_STAT, 32'h0000_000B, "status_push_on_pop");  // cnt1 full busy
        bus_write(A_DATA, 8'h77);                               // held byte waits: dropped
        bus_read(A_STAT, 32'h0000_000F, "status_ovf_set");
        bus_write(A_STAT, 8'h00);
        bus_read(A_STAT, 32'h0000_000B, "status_ovf_cleared");
        bus_idle(2 * FRAME_CYC + 100);
        bus_read(A_STAT, 32'h0, "status_drained");
`endif

        // Unmapped address: no queue change, reads 0.
        bus_write(A_BAD, 8'h99);
        bus_read(A_STAT, 32'h0, "status_after_bad_write");
        bus_read(A_BAD, 32'h0, "read_unmapped");
        bus_idle(300);

        // Reset about 300 cycles into a frame with another byte queued.
        bus_write(A_DATA, 8'h5A);
        expect_frame(8'h5A, 1'b0, 1'b1);
        bus_idle(2);
        bus_write(A_DATA, 8'hC3);
        bus_idle(296);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("tx_high_after_abort", 32'(tx), 32'd1);
        bus_read(A_STAT, 32'h0, "status_after_abort");
        bus_idle(2 * FRAME_CYC + 200);

        check("frames_outstanding", frame_q.size(), 0);
        check("reads_outstanding", rd_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
